// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: two cache line ports plus the shared DataMemory port, in one bundle.
//   slave  : arbiter view (takes cache requests and memory responses, drives done/rdata and memory requests)
//   master : environment view (the caches and DataMemory), directions mirrored
interface cache_mem_arbiter_if #(
    parameter int LINE_SIZE  = 16,
    parameter int ADDR_WIDTH = 32
);
    localparam int LINE_BITS = LINE_SIZE * 8;
    logic                  req0_valid, req1_valid;
    logic [ADDR_WIDTH-1:0] req0_addr, req1_addr;
    logic                  req0_write, req1_write;
    logic [LINE_BITS-1:0]  req0_wdata, req1_wdata;
    logic                  req0_done, req1_done;
    logic [LINE_BITS-1:0]  req0_rdata, req1_rdata;
    logic                  mem_is_input_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read, mem_write;
    logic [LINE_BITS-1:0]  mem_din;
    logic                  mem_is_output_valid;
    logic [LINE_BITS-1:0]  mem_dout;
    logic                  mem_ready;
    modport slave (
        input  req0_valid, req0_addr, req0_write, req0_wdata,
        input  req1_valid, req1_addr, req1_write, req1_wdata,
        output req0_done, req0_rdata, req1_done, req1_rdata,
        output mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din,
        input  mem_is_output_valid, mem_dout, mem_ready
    );
    modport master (
        output req0_valid, req0_addr, req0_write, req0_wdata,
        output req1_valid, req1_addr, req1_write, req1_wdata,
        input  req0_done, req0_rdata, req1_done, req1_rdata,
        input  mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din,
        output mem_is_output_valid, mem_dout, mem_ready
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin serialiser of whole-line I-cache (port 0) / D-cache (port 1) transactions onto one DataMemory.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus            : cache request/done ports and the DataMemory request/response port
//   grant_cnt0_o/1_o : completed transactions per port, wrapping
module cache_mem_arbiter #(
    parameter int LINE_SIZE  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    cache_mem_arbiter_if.slave bus,
    output logic [31:0]        grant_cnt0_o,
    output logic [31:0]        grant_cnt1_o
);
    localparam int LINE_BITS = LINE_SIZE * 8;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t                state_q;
    logic                  gnt_q, last_q, wr_q, done0_q, done1_q;
    logic [LINE_BITS-1:0]  rdata_q;
    logic [31:0]           cnt0_q, cnt1_q;
    logic                  pick_d, issue, sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_BITS-1:0]  sel_wdata;
    always_comb begin
        pick_d    = (bus.req0_valid && bus.req1_valid) ? !last_q : bus.req1_valid;
        issue     = state_q == ISSUE;
        sel_write = gnt_q ? bus.req1_write : bus.req0_write;
        sel_addr  = gnt_q ? bus.req1_addr : bus.req0_addr;
        sel_wdata = gnt_q ? bus.req1_wdata : bus.req0_wdata;
    end
    assign bus.mem_is_input_valid = issue;
    assign bus.mem_addr           = issue ? sel_addr : '0;
    assign bus.mem_read           = issue && !sel_write;
    assign bus.mem_write          = issue && sel_write;
    assign bus.mem_din            = issue ? sel_wdata : '0;
    assign bus.req0_done          = done0_q;
    assign bus.req1_done          = done1_q;
    assign bus.req0_rdata         = rdata_q;
    assign bus.req1_rdata         = rdata_q;
    assign grant_cnt0_o           = cnt0_q;
    assign grant_cnt1_o           = cnt1_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rdata_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            unique case (state_q)
                IDLE: if (bus.req0_valid || bus.req1_valid) begin
                    gnt_q   <= pick_d;
                    last_q  <= pick_d;
                    state_q <= ISSUE;
                end
                // The op is captured at accept so WAIT does not depend on the requester holding its inputs.
                ISSUE: if (bus.mem_ready) begin
                    wr_q    <= sel_write;
                    state_q <= WAIT;
                end
                // Memory drops ready after accept, so a ready seen here is the write completion.
                WAIT: if (wr_q ? bus.mem_ready : bus.mem_is_output_valid) begin
                    if (!wr_q) rdata_q <= bus.mem_dout;
                    done0_q <= !gnt_q;
                    done1_q <= gnt_q;
                    state_q <= DONE;
                end
                DONE: begin
                    if (gnt_q) cnt1_q <= cnt1_q + 32'd1;
                    else cnt0_q <= cnt0_q + 32'd1;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-port arbiter that shares one line-granular backing DataMemory between the instruction cache (port 0) and the data cache (port 1). It sits between the two caches' miss/write-back interfaces and the single DataMemory instance. It serialises whole-line reads and writes, grants round-robin on contention, and returns a one-cycle completion pulse with read data to the winning cache. Each cache sees a private memory port; DataMemory sees one requester.

## Interface
- LINE_SIZE, 16, line size in bytes; LINE_BITS = LINE_SIZE*8
- ADDR_WIDTH, 32, width of line (block) address, already shifted by CLOG2(LINE_SIZE)
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  port requests a line transaction; held until done
- req0_addr / req1_addr  in  ADDR_WIDTH  line address
- req0_write / req1_write  in  1  1 = write line, 0 = read line
- req0_wdata / req1_wdata  in  LINE_BITS  write line data
- req0_done / req1_done  out  1  one-cycle completion pulse
- req0_rdata / req1_rdata  out  LINE_BITS  read line, valid when done (reads only)
- mem_is_input_valid  out  1  request to DataMemory
- mem_addr  out  ADDR_WIDTH  line address to DataMemory
- mem_read / mem_write  out  1  operation select, one-hot when valid
- mem_din  out  LINE_BITS  write data
- mem_is_output_valid  in  1  DataMemory read data valid
- mem_dout  in  LINE_BITS  DataMemory read data
- mem_ready  in  1  DataMemory accepts a request
- grant_cnt0 / grant_cnt1  out  32  completed transactions per port, wrap modulo 2^32

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Registers: state, gnt (owner, 1 bit), last_gnt, latched rdata, grant counters.
- IDLE: if exactly one reqN_valid, gnt <= N. If both are valid, gnt <= !last_gnt. Either case then goes to ISSUE and last_gnt <= gnt. If none is valid, stay in IDLE.
- ISSUE: drive mem_is_input_valid=1, mem_addr/mem_read/mem_write/mem_din from the granted port, combinationally from that port's inputs. If mem_ready=1, the request is accepted that cycle and the FSM goes to WAIT. Otherwise stay in ISSUE and keep driving.
- WAIT: all mem_* request outputs are 0.
  - Read completes on mem_is_output_valid=1: latch mem_dout, go to DONE.
  - Write completes on the first cycle with mem_ready=1. DataMemory drops mem_ready the cycle after accept, so this is the first ready cycle after that drop.
- DONE: reqN_done=1 for the granted port only. reqN_rdata = latched line (read); its value is unspecified for writes. grant_cntN increments. Next state is IDLE.
- The non-granted port's done is always 0. Its request waits, with no starvation: after any completion with both ports valid, the other port wins next.
- A requester must hold valid/addr/write/wdata stable from assertion until it samples done, and must drop valid the cycle after done unless it starts a new request.
- If valid drops early, the in-flight transaction still completes and done still pulses.
- mem_read and mem_write are both 0 whenever mem_is_input_valid=0.

## Timing
- Reset values: state=IDLE, last_gnt=1 (port 0 wins the first tie), gnt=0. All done, mem_is_input_valid, mem_read and mem_write are 0. rdata=0, both counters=0.
- Minimum latency, valid to done: 1 (IDLE) + 1 (ISSUE, if mem_ready) + memory latency L (WAIT) + 1 (DONE).
- Back-to-back requests: one IDLE cycle between DONE and the next ISSUE; no overlap of transactions.
- Reset mid-transaction (any state) returns to IDLE next edge with outputs at reset values. DataMemory shares the reset, so no stale mem_is_output_valid is honoured; no done is emitted for the aborted transaction.
- Counter wrap: 0xFFFFFFFF + 1 = 0.
- A request arriving in the same cycle as DONE is sampled in the following IDLE cycle.

## Test plan
- Single read, port 0, addr 0x10, DataMemory preloaded line 0x10 = 128'hA5..A5 -> one req0_done pulse with rdata = 128'hA5..A5; req1_done stays 0; grant_cnt0 = 1.
- Single write, port 1, addr 0x3, wdata 128'h1234..; then port 0 reads 0x3 -> read returns 128'h1234..; grant_cnt1 = 1, grant_cnt0 = 1.
- Both ports valid in the first cycle after reset -> port 0 is served first, then port 1. With both held valid continuously for 6 transactions, the grant order is 0,1,0,1,0,1.
- Hold mem_ready=0 for 5 cycles during ISSUE -> mem_is_input_valid stays 1 with stable addr for all 5 cycles; exactly one accept; done arrives L+1 cycles after ready rises.
- Assert reset in WAIT of a read -> no done; all outputs at reset values next cycle. A subsequent read to the same address completes normally.
- Force grant_cnt0 to 0xFFFFFFFF, then complete one port-0 read -> grant_cnt0 = 0.
